// File: rtl/clz_pkg.sv
// rtl/clz_pkg.sv - shared types and sizing for the iterative CLZ/CLO sequencer
package clz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CLZ_WIDTH  = 32;
  localparam int CLZ_CHUNK  = 8;
  localparam int CLZ_CHUNKS = CLZ_WIDTH / CLZ_CHUNK;
  localparam int CLZ_CNT_W  = $clog2(CLZ_WIDTH) + 1;

endpackage

// File: rtl/clz_chunk.sv
// rtl/clz_chunk.sv - combinational leading-zero count of one chunk
// Output is CHUNK when the chunk is all zero.
module clz_chunk #(
  parameter int CHUNK = 8,
  parameter int LZ_W  = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] chunk_i,
  output logic [LZ_W-1:0]  lz_o
);

  // Ascending scan: the highest set bit is visited last and therefore wins.
  always_comb begin
    lz_o = LZ_W'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk_i[i]) begin
        lz_o = LZ_W'(CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/clz_iter_ctrl.sv
// rtl/clz_iter_ctrl.sv - multi-cycle CLZ/CLO sequencer, one chunk per cycle
// Stalls the pipeline from issue through the resolving scan; result is held.
module clz_iter_ctrl
  import clz_pkg::*;
#(
  parameter int WIDTH = CLZ_WIDTH,
  parameter int CHUNK = CLZ_CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_clo_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      result_o,
  output logic             stall_o
);

  localparam int CHUNKS = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int LZ_W   = $clog2(CHUNK + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [31:0]        result_q, result_d;
  logic [LZ_W-1:0]    lz_w;

  clz_chunk #(
    .CHUNK (CHUNK),
    .LZ_W  (LZ_W)
  ) u_chunk (
    .chunk_i (opnd_q[WIDTH-1 -: CHUNK]),
    .lz_o    (lz_w)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  // CLO is folded into CLZ by inverting the operand at latch time.
  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    result_d = result_q;
    stall_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o = start_i;
        if (start_i && !flush_i) begin
          state_d = SCAN;
          opnd_d  = op_clo_i ? ~a_i : a_i;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      SCAN: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (lz_w < LZ_W'(CHUNK)) begin
          result_d = 32'(cnt_q + CNT_W'(lz_w));
          state_d  = DONE;
        end else if (idx_q == CNT_W'(CHUNKS - 1)) begin
          result_d = 32'(WIDTH);
          state_d  = DONE;
        end else begin
          cnt_d  = cnt_q + CNT_W'(CHUNK);
          idx_d  = idx_q + CNT_W'(1);
          opnd_d = opnd_q << CHUNK;
        end
      end
      DONE: begin
        stall_o = start_i;
        if (flush_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          state_d = SCAN;
          opnd_d  = op_clo_i ? ~a_i : a_i;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o   = (state_q == SCAN);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_clz_iter_ctrl.sv
// tb/tb_clz_iter_ctrl.sv - self-checking bench for clz_iter_ctrl
module tb_clz_iter_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op_clo;
  logic [31:0] a;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall;

  int n_tests;
  int n_fail;
  logic [31:0] last_res;

  clz_iter_ctrl dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_clo_i (op_clo),
    .a_i      (a),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .stall_o  (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ref_count(input logic clo, input logic [31:0] av);
    logic [31:0] v;
    int n;
    v = clo ? ~av : av;
    n = 0;
    while (n < 32 && v[31-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic int ref_latency(input int cnt);
    return (cnt >= 32) ? 4 : (cnt / 8) + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic clo, input logic [31:0] av);
    start  = 1'b1;
    op_clo = clo;
    a      = av;
    #1;
    chk("stall_on_issue", {31'd0, stall}, 32'd1);
  endtask

  // Walks the operation from E0 to its DONE cycle and returns sitting in DONE.
  task automatic finish_op(input string tag, input logic clo, input logic [31:0] av);
    int exp_cnt;
    int lat;
    exp_cnt = ref_count(clo, av);
    lat     = ref_latency(exp_cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    #1;
    for (int k = 0; k < lat; k++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_early_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, "_hold"}, result, last_res);
      step();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk({tag, "_result"}, result, 32'(exp_cnt));
    last_res = 32'(exp_cnt);
  endtask

  task automatic to_idle(input string tag);
    step();
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    logic        clo;
    logic [31:0] av;
    n_tests  = 0;
    n_fail   = 0;
    last_res = 32'd0;
    rst    = 1'b1;
    start  = 1'b0;
    op_clo = 1'b0;
    a      = 32'd0;
    flush  = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_result", result, 32'd0);
    start = 1'b1;
    #1;
    chk("rst_stall_start", {31'd0, stall}, 32'd1);
    start = 1'b0;
    step();
    rst = 1'b0;
    step();

    issue(1'b0, 32'h8000_0000);
    finish_op("clz_msb", 1'b0, 32'h8000_0000);
    to_idle("clz_msb");

    issue(1'b0, 32'h0000_0001);
    finish_op("clz_lsb", 1'b0, 32'h0000_0001);
    to_idle("clz_lsb");

    issue(1'b0, 32'h0000_0000);
    finish_op("clz_zero", 1'b0, 32'h0000_0000);
    to_idle("clz_zero");

    issue(1'b1, 32'hFFFF_FFFF);
    finish_op("clo_ones", 1'b1, 32'hFFFF_FFFF);
    to_idle("clo_ones");

    issue(1'b1, 32'hFFF0_1234);
    finish_op("clo_12", 1'b1, 32'hFFF0_1234);
    to_idle("clo_12");

    issue(1'b0, 32'h0001_0000);
    finish_op("b2b_first", 1'b0, 32'h0001_0000);
    issue(1'b0, 32'h4000_0000);
    finish_op("b2b_second", 1'b0, 32'h4000_0000);
    to_idle("b2b");

    // Flush in the second SCAN cycle: no done, result untouched.
    issue(1'b0, 32'h0000_FFFF);
    step();
    start = 1'b0;
    step();
    chk("flush_busy_pre", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, last_res);
    step();
    chk("flush_no_done", {31'd0, done}, 32'd0);

    // Flush racing a start in IDLE: nothing is latched.
    start = 1'b1;
    flush = 1'b1;
    a     = 32'h0000_0001;
    step();
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    step();
    chk("flush_start_done", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-SCAN, released between edges.
    issue(1'b0, 32'h0000_0001);
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_result", result, 32'd0);
    #3;
    rst = 1'b0;
    last_res = 32'd0;
    step();
    issue(1'b0, 32'h0080_0000);
    finish_op("post_rst", 1'b0, 32'h0080_0000);
    to_idle("post_rst");

    // Randomized operands spread across all latencies, random back-to-back.
    for (int t = 0; t < 40; t++) begin
      clo = 1'($urandom_range(0, 1));
      av  = $urandom >> $urandom_range(0, 32);
      if (clo) av = ~av;
      issue(clo, av);
      finish_op("rand", clo, av);
      if ($urandom_range(0, 2) == 0) to_idle("rand");
    end
    to_idle("rand_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clz_iter_ctrl.md
# clz_iter_ctrl

Multi-cycle sequencer for the MIPS CLZ/CLO instructions. It scans a 32-bit operand one 8-bit chunk per cycle, using a small combinational chunk counter, instead of a full-width priority chain. It sits beside the ALU in the execute stage and raises a stall to the pipeline until the count is ready. The pipeline sees a `start`/`done` handshake and a held result.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of `CHUNK`.
- `CHUNK`, default 8: bits examined per scan cycle.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a count; sampled only in IDLE or DONE.
- `op_clo` in 1: 1 = count leading ones (CLO), 0 = count leading zeros (CLZ); sampled with `start`.
- `a` in WIDTH: operand; sampled with `start`.
- `flush` in 1: synchronous abort from the pipeline (branch/exception).
- `busy` out 1: high while in SCAN.
- `done` out 1: one-cycle pulse; `result` is valid this cycle.
- `result` out 32: count, 0..WIDTH, zero-extended; held until the next accepted result.
- `stall` out 1: pipeline hold request.

## Operation
- The FSM has three states:
  - IDLE: `start` → SCAN. Latch `opnd = op_clo ? ~a : a`, `cnt = 0`, `idx = 0`.
  - SCAN: each edge, `lz = chunk leading zeros` of `opnd[WIDTH-1 -: CHUNK]` (0..CHUNK).
    - `lz < CHUNK` → `result <= cnt + lz`, go to DONE.
    - Otherwise, if `idx == CHUNKS-1` → `result <= WIDTH`, go to DONE.
    - Otherwise `cnt += CHUNK`, `opnd <<= CHUNK`, `idx++`.
  - DONE: `done = 1` for exactly this cycle.
    - `start` → SCAN with a fresh latch (back-to-back).
    - No `start` → IDLE.
- `busy = (state == SCAN)`, `done = (state == DONE)`. Both are decoded from registered state.
- `stall = (state == SCAN) | ((state == IDLE | state == DONE) & start)`. This is combinational, so the requester holds from the issue cycle through the last scan.
- `start` in SCAN is ignored. The requester holds its instruction via `stall`.
- Arithmetic:
  - `cnt` and `idx` are unsigned, `$clog2(WIDTH)+1` bits; no overflow is possible.
  - `result` upper bits are zero.
- `flush`:
  - In SCAN or DONE: next state IDLE, and `result` is unchanged.
  - Same cycle as `start` in IDLE: `flush` wins and nothing is latched.
- `rst` (any time, including mid-SCAN): state IDLE, `result = 0`, `cnt = 0`, `idx = 0`, `opnd = 0`.
  - Outputs in reset: `busy = 0`, `done = 0`, `stall = 0` unless `start` is high.

## Timing
- `start` is accepted at edge E0.
- Chunk k (MSB-first) is evaluated at edge E(k+1).
- `done` is high in the cycle after the resolving edge.
- Latency (E0 to the `done` cycle) = index of the first chunk containing a 1 (after the CLO inversion) + 1.
  - Range is 1 to `CHUNKS` cycles: 1..4 at the defaults.
  - An all-zero operand (CLZ) or all-one operand (CLO) takes the full `CHUNKS` cycles.
- Back-to-back: `start` in the DONE cycle is latched on that edge. No idle bubble.
- No combinational path from `a` to `result`.
- One path runs from `start` to `stall`.

## Structure
- Shared package `clz_pkg`:
  - state enum {IDLE, SCAN, DONE}
  - `CLZ_WIDTH = 32`
  - `CLZ_CHUNK = 8`
  - derived `CLZ_CHUNKS`
  - `CLZ_CNT_W = $clog2(CLZ_WIDTH) + 1`
- One sub-module `clz_chunk`: combinational CHUNK-bit leading-zero counter, output 0..CHUNK (CHUNK when the input is all zero).
- Everything else (FSM, `opnd` shift register, `cnt`/`idx` counters, result register) lives in `clz_iter_ctrl`.

## Test plan
- CLZ, `a = 0x80000000`, `start` one cycle → `stall` high 2 cycles (issue + SCAN); `done` 1 cycle after E0; `result = 0`.
- CLZ, `a = 0x00000001` → three SCAN cycles plus the resolving one; `done` at E0+4; `result = 31`.
- CLZ `a = 0x00000000` → `result = 32` after 4 scans.
- CLO `a = 0xFFFFFFFF` → `result = 32`.
- CLO `a = 0xFFF0_1234` → `result = 12`, `done` at E0+2.
- Back-to-back: CLZ `0x00010000` (→ 15) then `start` during its DONE with CLZ `0x40000000` (→ 1).
  - Two `done` pulses.
  - No IDLE cycle between them.
  - `result` updates 15 → 1.
- `flush` in the second SCAN cycle of CLZ `0x0000FFFF` → IDLE next cycle; no `done`; `result` keeps the previous value.
- `rst` asserted mid-SCAN and released asynchronously between edges → outputs 0 immediately; a fresh CLZ `0x00800000` afterwards returns 8.
